serial_subtractor_nbit: RTL and testbench
=========================================

Name: serial_subtractor_nbit

Overview:
Bit-serial N-bit subtractor, computing a - b one bit per clock, LSB first. Internally it is a single full-adder cell: b is inverted and the initial carry is 1, so the result is a + ~b + 1.
Operands enter through a valid/ready input handshake. The result leaves through a valid/ready output handshake, together with an unsigned borrow flag and a signed overflow flag.
It is the inverse-operation counterpart to the combinational n-bit adder. It targets area-constrained datapaths where N cycles of latency are acceptable.

Parameters:
N, 4, operand/result width in bits; legal range N >= 2.
CW, $clog2(N), width of the internal bit counter.

Ports:
clk        input   1   rising-edge clock.
rst        input   1   synchronous, active-high reset.
in_valid   input   1   a/b operands valid.
in_ready   output  1   block can accept operands.
a          input   N   minuend (two's complement or unsigned).
b          input   N   subtrahend.
out_valid  output  1   diff/borrow/overflow valid.
out_ready  input   1   downstream accepts the result.
diff       output  N   a - b modulo 2^N.
borrow     output  1   1 when unsigned a < b.
overflow   output  1   1 when the signed result does not fit in N bits.

Behaviour:
- Reset: one clock, synchronous, active-high; the polarity and synchronicity are fixed.
  - rst sampled high at a rising edge: state <= IDLE, in_ready = 1, out_valid = 0, diff = 0, borrow = 0, overflow = 0.
  - Internal shift registers, carry and counter are cleared.
  - rst takes priority over every other input.
  - rst in SHIFT or DONE aborts the operation; no partial result is ever presented.
- State machine, three states:
  - IDLE: in_ready = 1, out_valid = 0. On in_valid && in_ready, capture a -> a_sr and b -> b_sr; set carry <= 1 and cnt <= 0; next state SHIFT.
  - SHIFT: in_ready = 0, out_valid = 0. Each cycle:
    - s = a_sr[0] ^ ~b_sr[0] ^ carry.
    - carry <= majority(a_sr[0], ~b_sr[0], carry).
    - d_sr <= {s, d_sr[N-1:1]}.
    - a_sr and b_sr shift right by 1; cnt <= cnt + 1.
    - At cnt == N-1 the next state is DONE.
  - DONE: in_ready = 0, out_valid = 1. On out_ready the next state is IDLE.
- Outputs in DONE:
  - diff = d_sr.
  - borrow = ~carry_final.
  - overflow = (a_msb != b_msb) && (diff[N-1] != a_msb), where a_msb and b_msb are the operand MSBs latched at capture.
- Latency and throughput:
  - Operands accepted at edge k; out_valid is high after edge k+N.
  - Minimum issue interval is N+2 cycles: accept, N shift cycles, result handshake, return to IDLE.
  - in_ready is never asserted in the same cycle as out_valid; there is no overlap.
- Handshake rules:
  - in_valid while in_ready = 0 is ignored; the operands are not queued.
  - diff, borrow and overflow are held stable for the entire time out_valid = 1, including while out_ready is low for any number of cycles.
  - out_valid drops in the cycle after the edge where out_valid && out_ready is sampled.
  - a and b may change freely after capture without affecting the result.
- Arithmetic:
  - diff is exact modulo 2^N.
  - Wrap-around case: a = 0, b = 1 gives diff = all ones, borrow = 1.
  - a == b gives diff = 0, borrow = 0, overflow = 0.
- X/Z: X or Z bits captured on a or b propagate to diff, borrow and overflow as X. The control path (state, cnt, in_ready, out_valid) must never go X after reset.

Test Plan:
- Basic, N=4: a = 0111, b = 0010 -> after 4 shift cycles diff = 0101, borrow = 0, overflow = 0; out_valid high exactly at edge k+4.
- Borrow: a = 0010, b = 0101 -> diff = 1101, borrow = 1, overflow = 0. Wrap: a = 0000, b = 0001 -> diff = 1111, borrow = 1, overflow = 0.
- Signed overflow: a = 0111, b = 1000 -> diff = 1111, borrow = 1, overflow = 1. Then a = 1000, b = 0001 -> diff = 0111, borrow = 0, overflow = 1.
- Backpressure and ignored input:
  - Hold out_ready = 0 for 5 cycles in DONE -> outputs stable, in_ready stays 0.
  - Pulse in_valid with a = 1111, b = 0000 during SHIFT -> ignored; the original result is delivered.
- Back-to-back with out_ready tied to 1: 20 random operand pairs -> each result matches {borrow, diff} = {a < b, (a - b) mod 16} and the overflow formula; issue interval is exactly 6 cycles.
- Reset:
  - Assert rst at shift cycle 2 -> next cycle in state IDLE, out_valid = 0, diff = 0, in_ready = 1.
  - A new operation a = 0101, b = 0101 then gives diff = 0000, borrow = 0, overflow = 0.

Source files
------------

// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: computes a - b one bit per clock, LSB first,
// using a single full-adder cell fed with a, ~b and an initial carry of 1.
// Operands arrive through a valid/ready handshake. diff/borrow/overflow leave
// through a second valid/ready handshake and stay stable until accepted.
module serial_subtractor_nbit #(
    parameter int N  = 4,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow,
    output logic         overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  a_sr_q, a_sr_d;
    logic [N-1:0]  b_sr_q, b_sr_d;
    logic [N-1:0]  d_sr_q, d_sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          a_msb_q, a_msb_d;
    logic          b_msb_q, b_msb_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          borrow_q, borrow_d;
    logic          overflow_q, overflow_d;

    logic          fa_a, fa_b, fa_sum, fa_carry;

    // Full-adder cell on the current LSBs, with the subtrahend inverted.
    always_comb begin
        fa_a     = a_sr_q[0];
        fa_b     = ~b_sr_q[0];
        fa_sum   = fa_a ^ fa_b ^ carry_q;
        fa_carry = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
    end

    // Next-state logic for the control FSM, the shift datapath and the result flags.
    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        d_sr_d      = d_sr_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        borrow_d    = borrow_q;
        overflow_d  = overflow_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sr_d     = a;
                    b_sr_d     = b;
                    a_msb_d    = a[N-1];
                    b_msb_d    = b[N-1];
                    carry_d    = 1'b1;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                carry_d = fa_carry;
                d_sr_d  = {fa_sum, d_sr_q[N-1:1]};
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // fa_sum here is the result MSB, so the flags are final this cycle.
                    borrow_d    = ~fa_carry;
                    overflow_d  = (a_msb_q != b_msb_q) && (fa_sum != a_msb_q);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    borrow_d    = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            d_sr_q      <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            borrow_q    <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            d_sr_q      <= d_sr_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            borrow_q    <= borrow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = d_sr_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Self-checking bench for serial_subtractor_nbit at N = 4: directed vectors,
// backpressure, ignored input during a shift, back-to-back issue and reset abort.
module tb_serial_subtractor_nbit;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         borrow;
    logic         overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] diff;
        logic       borrow;
        logic       ovf;
    } vec_t;

    vec_t vecs[8];

    serial_subtractor_nbit #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .borrow   (borrow),
        .overflow (overflow)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Cycle counter used to measure the issue interval.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Offers one operand pair in IDLE and lets the accepting edge pass;
    // the operand inputs are then scrambled to show they are not re-read.
    task automatic applyStimulus(input string name, input logic [3:0] av, input logic [3:0] bv);
        checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        tick();
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    task automatic runVector(input string name, input vec_t v);
        int c;
        applyStimulus(name, v.a, v.b);
        waitDone(c);
        checkOutput({name, "_latency"}, 32'(c), 32'(N));
        checkOutput({name, "_result"}, 32'({in_ready, borrow, overflow, diff}),
                    32'({1'b0, v.borrow, v.ovf, v.diff}));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({name, "_release"}, 32'({out_valid, in_ready}), 32'(2'b01));
    endtask

    initial begin
        int         c;
        int         t_prev;
        int         t_now;
        logic [3:0] ra, rb, ed;
        logic       eb, eo;

        vecs[0] = '{4'b0111, 4'b0010, 4'b0101, 1'b0, 1'b0};
        vecs[1] = '{4'b0010, 4'b0101, 4'b1101, 1'b1, 1'b0};
        vecs[2] = '{4'b0000, 4'b0001, 4'b1111, 1'b1, 1'b0};
        vecs[3] = '{4'b0111, 4'b1000, 4'b1111, 1'b1, 1'b1};
        vecs[4] = '{4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1};
        vecs[5] = '{4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b0};
        vecs[6] = '{4'b1111, 4'b0000, 4'b1111, 1'b0, 1'b0};
        vecs[7] = '{4'b0011, 4'b1110, 4'b0101, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_state", 32'({in_ready, out_valid, borrow, overflow, diff}), 32'(8'b1000_0000));

        for (int i = 0; i < 8; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Backpressure: result held for five cycles with out_ready low.
        applyStimulus("bp", 4'b0111, 4'b0010);
        waitDone(c);
        checkOutput("bp_latency", 32'(c), 32'(N));
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_hold", 32'({out_valid, in_ready, borrow, overflow, diff}), 32'(8'b1000_0101));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_release", 32'({out_valid, in_ready}), 32'(2'b01));

        // in_valid pulsed mid-shift must be ignored.
        applyStimulus("ign", 4'b0010, 4'b0101);
        in_valid = 1'b1;
        a        = 4'b1111;
        b        = 4'b0000;
        tick();
        tick();
        in_valid = 1'b0;
        waitDone(c);
        checkOutput("ign_latency", 32'(c), 32'(N - 2));
        checkOutput("ign_result", 32'({borrow, overflow, diff}), 32'(6'b10_1101));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("ign_no_queue", 32'({out_valid, in_ready}), 32'(2'b01));
        end

        // Back-to-back with out_ready held high: 20 random pairs, 6-cycle interval.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        t_prev    = 0;
        for (int i = 0; i < 20; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            a  = ra;
            b  = rb;
            c  = 0;
            while (in_ready !== 1'b1 && c < 20) begin
                tick();
                c++;
            end
            t_now = cyc;
            if (i > 0) checkOutput("b2b_interval", 32'(t_now - t_prev), 32'd6);
            t_prev = t_now;
            tick();
            a = ~ra;
            b = ~rb;
            waitDone(c);
            ed = ra - rb;
            eb = (ra < rb);
            eo = (ra[3] != rb[3]) && (ed[3] != ra[3]);
            checkOutput($sformatf("b2b_result_%0h_%0h", ra, rb),
                        32'({c[7:0], borrow, overflow, diff}), 32'({8'(N), eb, eo, ed}));
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checkOutput("b2b_drain", 32'({out_valid, in_ready}), 32'(2'b01));

        // Reset during the second shift cycle aborts the operation.
        applyStimulus("rst_abort", 4'b0111, 4'b0010);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_abort_state", 32'({in_ready, out_valid, borrow, overflow, diff}), 32'(8'b1000_0000));
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("rst_no_partial", 32'({out_valid, in_ready}), 32'(2'b01));
        end
        runVector("post_rst", '{4'b0101, 4'b0101, 4'b0000, 1'b0, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
